// File: rtl/adder_result_checker.sv
// Predicts a+b for every captured operand pair and checks it against the adder's c.
// Latency: compare occurs LATENCY edges after capture; result outputs update on that edge.
// Backpressure: none; passive observer, never stalls or drives the adder interface.
module adder_result_checker #(
    parameter int WIDTH        = 4,
    parameter int LATENCY      = 1,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             valid,
    input  logic [WIDTH:0]   c,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             mismatch,
    output logic [WIDTH:0]   exp_c,
    output logic [WIDTH:0]   got_c,
    output logic             err_sticky,
    output logic [3:0]       in_flight,
    output logic             halted
);

    localparam int LAST = LATENCY - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LATENCY-1:0] tag_q;
    logic [WIDTH:0]     exp_q [LATENCY];

    logic [WIDTH:0] sum;
    logic           capture;
    logic           cmp_vld;
    logic           cmp_fail;

    // Carry kept: the prediction is one bit wider than the operands.
    assign sum      = {1'b0, a} + {1'b0, b};
    assign capture  = valid && (state_q == RUN) && !clr;
    assign cmp_vld  = tag_q[LAST] && !clr;
    assign cmp_fail = cmp_vld && (exp_q[LAST] != c);
    assign halted   = (state_q == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!clr && en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (clr) begin
                    state_d = IDLE;
                end else if (cmp_fail && (STOP_ON_FAIL != 0)) begin
                    state_d = HALT;
                end else if (!en) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                if (clr) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Tags shift in every state so in-flight entries drain even when not capturing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q <= '0;
        end else if (clr) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= capture;
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                exp_q[i] <= '0;
            end
        end else begin
            exp_q[0] <= sum;
            for (int i = 1; i < LATENCY; i++) begin
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            mismatch   <= 1'b0;
            exp_c      <= '0;
            got_c      <= '0;
            err_sticky <= 1'b0;
            in_flight  <= '0;
        end else if (clr) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            mismatch   <= 1'b0;
            exp_c      <= '0;
            got_c      <= '0;
            err_sticky <= 1'b0;
            in_flight  <= '0;
        end else begin
            mismatch  <= cmp_fail;
            in_flight <= in_flight + 4'(capture) - 4'(cmp_vld);
            if (cmp_vld && !cmp_fail && (pass_cnt != CNT_MAX)) begin
                pass_cnt <= pass_cnt + CNT_W'(1);
            end
            if (cmp_fail) begin
                if (fail_cnt != CNT_MAX) begin
                    fail_cnt <= fail_cnt + CNT_W'(1);
                end
                exp_c      <= exp_q[LAST];
                got_c      <= c;
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Two checkers (LATENCY=1 small counters; LATENCY=3 with STOP_ON_FAIL) observe a modelled adder.
// Expected results go into per-checker queues; a negedge monitor pops them when due.
module tb_adder_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, clr, valid;
    logic [3:0] a, b;
    logic [4:0] cmask;
    logic [4:0] line0;
    logic [4:0] line1 [3];

    logic [3:0]  pass_cnt0, fail_cnt0, in_flight0;
    logic [15:0] pass_cnt1, fail_cnt1;
    logic [3:0]  in_flight1;
    logic        mismatch0, err0, halted0, mismatch1, err1, halted1;
    logic [4:0]  exp_c0, got_c0, exp_c1, got_c1;

    typedef struct {
        int exp_v;
        int got_v;
        int due;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   cyc = 0;
    int   flush_seq = 0;
    int   seen_flush = 0;
    int   nchk = 0;
    int   nfail = 0;
    int   epass[2], efail[2], eexp[2], egot[2], eerr[2];

    // Adder under test: fixed-latency sum, optionally corrupted by cmask.
    always @(posedge clk) begin
        line0    <= ({1'b0, a} + {1'b0, b}) ^ cmask;
        line1[0] <= ({1'b0, a} + {1'b0, b}) ^ cmask;
        line1[1] <= line1[0];
        line1[2] <= line1[1];
    end

    always @(posedge clk) cyc <= cyc + 1;

    adder_result_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(4), .STOP_ON_FAIL(0)) dut0 (
        .clk(clk), .rst(rst), .a(a), .b(b), .valid(valid), .c(line0), .en(en), .clr(clr),
        .pass_cnt(pass_cnt0), .fail_cnt(fail_cnt0), .mismatch(mismatch0), .exp_c(exp_c0),
        .got_c(got_c0), .err_sticky(err0), .in_flight(in_flight0), .halted(halted0)
    );

    adder_result_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(16), .STOP_ON_FAIL(1)) dut1 (
        .clk(clk), .rst(rst), .a(a), .b(b), .valid(valid), .c(line1[2]), .en(en), .clr(clr),
        .pass_cnt(pass_cnt1), .fail_cnt(fail_cnt1), .mismatch(mismatch1), .exp_c(exp_c1),
        .got_c(got_c1), .err_sticky(err1), .in_flight(in_flight1), .halted(halted1)
    );

    task automatic chk(input string nm, input int act, input int req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic mon(input int id, input int pc, input int fc, input int mm, input int ec,
                       input int gc, input int es, input int inf, input int maxc);
        ent_t e;
        int   bad;
        int   qs;
        bad = 0;
        while (1) begin
            if (id == 0) begin
                if (q0.size() == 0 || q0[0].due > cyc) break;
                e = q0.pop_front();
            end else begin
                if (q1.size() == 0 || q1[0].due > cyc) break;
                e = q1.pop_front();
            end
            if (e.exp_v != e.got_v) begin
                bad = 1;
                if (efail[id] < maxc) efail[id]++;
                eexp[id] = e.exp_v;
                egot[id] = e.got_v;
                eerr[id] = 1;
            end else if (epass[id] < maxc) begin
                epass[id]++;
            end
        end
        qs = (id == 0) ? q0.size() : q1.size();
        chk($sformatf("d%0d pass_cnt", id), pc, epass[id]);
        chk($sformatf("d%0d fail_cnt", id), fc, efail[id]);
        chk($sformatf("d%0d mismatch", id), mm, bad);
        chk($sformatf("d%0d exp_c", id), ec, eexp[id]);
        chk($sformatf("d%0d got_c", id), gc, egot[id]);
        chk($sformatf("d%0d err_sticky", id), es, eerr[id]);
        chk($sformatf("d%0d in_flight", id), inf, qs);
    endtask

    // Monitor: independent of stimulus, compares every cycle.
    initial begin
        for (int i = 0; i < 2; i++) begin
            epass[i] = 0; efail[i] = 0; eexp[i] = 0; egot[i] = 0; eerr[i] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (flush_seq != seen_flush) begin
                seen_flush = flush_seq;
                for (int i = 0; i < 2; i++) begin
                    epass[i] = 0; efail[i] = 0; eexp[i] = 0; egot[i] = 0; eerr[i] = 0;
                end
            end
            mon(0, int'(pass_cnt0), int'(fail_cnt0), int'(mismatch0), int'(exp_c0),
                int'(got_c0), int'(err0), int'(in_flight0), 15);
            mon(1, int'(pass_cnt1), int'(fail_cnt1), int'(mismatch1), int'(exp_c1),
                int'(got_c1), int'(err1), int'(in_flight1), 65535);
        end
    end

    // k0/k1: whether dut0/dut1 is expected to capture at this edge.
    task automatic step(input int ta, input int tb_, input logic tv, input int cm,
                        input logic k0, input logic k1);
        ent_t e;
        a = 4'(ta); b = 4'(tb_); valid = tv; cmask = 5'(cm);
        @(posedge clk);
        if (clr) begin
            q0.delete(); q1.delete(); flush_seq++;
        end else begin
            e.exp_v = ta + tb_;
            e.got_v = (ta + tb_) ^ cm;
            if (k0) begin e.due = cyc + 2; q0.push_back(e); end
            if (k1) begin e.due = cyc + 4; q1.push_back(e); end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pk;
        rst = 1'b0; en = 1'b0; clr = 1'b0; valid = 1'b0; a = '0; b = '0; cmask = '0;
        repeat (2) @(negedge clk);
        chk("reset pass_cnt0", int'(pass_cnt0), 0);
        chk("reset in_flight1", int'(in_flight1), 0);
        chk("reset halted1", int'(halted1), 0);
        chk("reset err1", int'(err1), 0);
        #2 rst = 1'b1;

        // 1: single transaction, 3+5=8.
        en = 1'b1;
        idle(1);
        step(3, 5, 1'b1, 0, 1'b1, 1'b1);
        chk("t1 in_flight0 after capture", int'(in_flight0), 1);
        idle(3);
        chk("t1 pass_cnt0", int'(pass_cnt0), 1);
        chk("t1 pass_cnt1", int'(pass_cnt1), 1);

        // 2: carry case 15+15=30, then c forced to 14 (30^16).
        step(15, 15, 1'b1, 0, 1'b1, 1'b1);
        step(15, 15, 1'b1, 16, 1'b1, 1'b1);
        idle(3);
        chk("t2 pass_cnt0", int'(pass_cnt0), 2);
        chk("t2 fail_cnt0", int'(fail_cnt0), 1);
        chk("t2 exp_c0", int'(exp_c0), 30);
        chk("t2 got_c0", int'(got_c0), 14);
        chk("t2 err0", int'(err0), 1);
        chk("t2 halted1", int'(halted1), 1);
        clr = 1'b1; idle(1); clr = 1'b0;
        chk("t2 clr halted1", int'(halted1), 0);
        chk("t2 clr err0", int'(err0), 0);

        // 3: first of five fails; dut1 halts after its compare, stops capturing.
        idle(1);
        step(1, 2, 1'b1, 1, 1'b1, 1'b1);
        step(2, 3, 1'b1, 0, 1'b1, 1'b1);
        step(3, 4, 1'b1, 0, 1'b1, 1'b1);
        chk("t3 halted1 before fail", int'(halted1), 0);
        step(4, 5, 1'b1, 0, 1'b1, 1'b1);
        chk("t3 halted1 after fail", int'(halted1), 1);
        step(5, 6, 1'b1, 0, 1'b1, 1'b0);
        idle(3);
        chk("t3 pass_cnt1", int'(pass_cnt1), 3);
        chk("t3 fail_cnt1", int'(fail_cnt1), 1);
        chk("t3 pass_cnt0", int'(pass_cnt0), 4);
        chk("t3 halted0", int'(halted0), 0);
        step(7, 7, 1'b1, 0, 1'b1, 1'b0);
        chk("t3 halted in_flight1", int'(in_flight1), 0);
        clr = 1'b1; idle(1); clr = 1'b0;
        chk("t3 clr halted1", int'(halted1), 0);
        chk("t3 clr fail_cnt1", int'(fail_cnt1), 0);

        // 4: ten back-to-back on LATENCY=3, then saturate dut0's 4-bit counter.
        idle(1);
        pk = 0;
        for (int i = 0; i < 10; i++) begin
            step(i, (i * 7) % 16, 1'b1, 0, 1'b1, 1'b1);
            if (int'(in_flight1) > pk) pk = int'(in_flight1);
        end
        chk("t4 in_flight1 peak", pk, 3);
        idle(2);
        chk("t4 in_flight1 +2", int'(in_flight1), 1);
        idle(1);
        chk("t4 in_flight1 +3", int'(in_flight1), 0);
        chk("t4 pass_cnt1", int'(pass_cnt1), 10);
        for (int i = 0; i < 8; i++) step(i + 8, 3, 1'b1, 0, 1'b1, 1'b1);
        idle(3);
        chk("t4 pass_cnt0 saturated", int'(pass_cnt0), 15);
        chk("t4 pass_cnt1", int'(pass_cnt1), 18);

        // 5: asynchronous reset with two entries in flight.
        step(2, 2, 1'b1, 0, 1'b1, 1'b1);
        step(3, 3, 1'b1, 0, 1'b1, 1'b1);
        chk("t5 in_flight1 before rst", int'(in_flight1), 2);
        #2 rst = 1'b0; valid = 1'b0;
        #1;
        chk("t5 async pass_cnt1", int'(pass_cnt1), 0);
        chk("t5 async in_flight1", int'(in_flight1), 0);
        chk("t5 async pass_cnt0", int'(pass_cnt0), 0);
        chk("t5 async in_flight0", int'(in_flight0), 0);
        q0.delete(); q1.delete(); flush_seq++;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        idle(4);
        chk("t5 no late compare dut1", int'(pass_cnt1), 0);
        chk("t5 no late compare dut0", int'(pass_cnt0), 0);

        // 6: clr coincident with valid; then en dropped with entries pending.
        step(1, 1, 1'b1, 0, 1'b1, 1'b1);
        step(1, 1, 1'b1, 0, 1'b1, 1'b1);
        idle(3);
        chk("t6 pass_cnt1 pre-clr", int'(pass_cnt1), 2);
        step(6, 6, 1'b1, 0, 1'b1, 1'b1);
        clr = 1'b1;
        step(7, 7, 1'b1, 0, 1'b0, 1'b0);
        clr = 1'b0;
        chk("t6 clr pass_cnt0", int'(pass_cnt0), 0);
        chk("t6 clr in_flight1", int'(in_flight1), 0);
        idle(1);
        step(8, 1, 1'b1, 0, 1'b1, 1'b1);
        step(2, 9, 1'b1, 0, 1'b1, 1'b1);
        en = 1'b0;
        step(4, 4, 1'b1, 0, 1'b1, 1'b1);
        step(5, 5, 1'b1, 0, 1'b0, 1'b0);
        idle(3);
        chk("t6 pass_cnt0", int'(pass_cnt0), 3);
        chk("t6 pass_cnt1", int'(pass_cnt1), 3);
        chk("t6 in_flight1", int'(in_flight1), 0);

        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Hardware response checker on the consuming end of the adder operand/valid interface.
- Snoops the operand handshake (a, b, valid) and predicts each sum.
- Aligns each prediction to the adder's fixed output latency, compares it against c, and keeps pass/fail statistics.
- Sits beside the adder instance in the bench top and in the FPGA self-test wrapper; it is a pure observer and drives nothing back into the adder.

Parameters:
- WIDTH, 4, operand width of a and b; c is WIDTH+1 bits.
- LATENCY, 1, number of clk edges from the edge sampling valid=1 to the edge at which the matching c is valid; legal range 1..8.
- CNT_W, 16, width of the pass and fail counters.
- STOP_ON_FAIL, 0, when 1 the checker halts capture after the first mismatch.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- a  in  WIDTH  operand A, sampled when valid=1.
- b  in  WIDTH  operand B, sampled when valid=1.
- valid  in  1  operand qualifier, same signal that drives the adder.
- c  in  WIDTH+1  adder result under check.
- en  in  1  capture enable for new transactions.
- clr  in  1  synchronous clear of counters, error state and in-flight pipeline.
- pass_cnt  out  CNT_W  number of matching results.
- fail_cnt  out  CNT_W  number of mismatching results.
- mismatch  out  1  one-cycle pulse per failing compare.
- exp_c  out  WIDTH+1  expected value of the most recent failure.
- got_c  out  WIDTH+1  observed c of the most recent failure.
- err_sticky  out  1  set on any failure, cleared only by rst or clr.
- in_flight  out  4  number of captured transactions not yet compared.
- halted  out  1  high while the FSM is in HALT.

Behaviour:
- Reset values (rst=0, asynchronous):
  - all outputs 0;
  - pipeline tags 0;
  - FSM in IDLE.
- FSM states:
  - IDLE: en=0; no capture.
  - RUN: en=1; capture enabled.
  - HALT: entered only when STOP_ON_FAIL=1.
- FSM transitions:
  - IDLE->RUN when en=1.
  - RUN->IDLE when en=0.
  - RUN->HALT on a failing compare when STOP_ON_FAIL=1.
  - HALT->IDLE only on clr=1.
  - rst forces IDLE from any state.
- Capture: at an edge with valid=1 and state RUN, push {tag=1, exp=a+b} into stage 0 of a LATENCY-deep shift pipeline. Otherwise push tag=0.
- Sum arithmetic: exp = zero-extend(a) + zero-extend(b) in WIDTH+1 bits, so the carry is kept and there is no wrap.
- Pipeline advance: the pipeline shifts every cycle in all states, so in-flight entries drain even in IDLE or HALT.
- Compare: at the edge where a tag=1 entry sits in the last stage (LATENCY edges after capture), compare it with c sampled at that same edge.
  - Equal: pass_cnt+1.
  - Unequal: fail_cnt+1, exp_c/got_c loaded, err_sticky=1, mismatch=1 for exactly the following cycle.
  - Compare happens in any state.
  - Compares after the first failure in HALT still count.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- in_flight equals the number of tag=1 stages. It updates the same edge as capture and compare; a simultaneous push and compare leaves it unchanged.
- clr=1 at an edge:
  - zeroes counters, exp_c, got_c, err_sticky, mismatch and all tags;
  - leaves the FSM in IDLE, re-entering RUN next edge if en=1.
  - clr has priority over simultaneous capture or compare; that transaction is discarded and not counted.
- Reset mid-operation: in-flight transactions are lost and are never compared after release.
- Back-to-back valid: one capture per cycle with no bubbles; in_flight maxes at LATENCY.

Test Plan:
1. LATENCY=1, en=1, a=3, b=5, valid for 1 cycle; c=8 one edge later -> pass_cnt=1, fail_cnt=0, mismatch never high, in_flight 1 then 0.
2. a=15, b=15, c=30 -> pass_cnt=1. Then c forced to 14 for a=15, b=15 -> fail_cnt=1, exp_c=30, got_c=14, mismatch high exactly 1 cycle, err_sticky=1.
3. STOP_ON_FAIL=1, mismatch on transaction 1 of 5 back-to-back -> halted=1 after that edge. No further captures; already in-flight entries still compared. clr -> halted=0, counters 0.
4. 10 back-to-back valids, LATENCY=3, correct c -> pass_cnt=10, in_flight peaks at 3, returns to 0 three edges after the last valid.
5. rst low for 1 cycle while in_flight=2 -> all outputs 0 immediately (asynchronous); no compare occurs after release.
6. clr and valid high at the same edge -> counters 0, in_flight=0, that transaction never counted. en dropped mid-flight -> pending entries still compared, no new captures.
